// File: rtl/ddr_axi4_mem_pkg.sv
// Shared types and constants for the BRAM-backed AXI4 memory responder.
`default_nettype none

package ddr_axi4_mem_pkg;

    localparam int          BEAT_BYTES  = 8;
    localparam logic [2:0]  SIZE_64     = 3'd3;
    localparam int          ID_MAX_W    = 16;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    typedef struct packed {
        logic [63:0]         data;
        logic [ID_MAX_W-1:0] id;
        logic [1:0]          resp;
        logic                last;
    } rd_beat_t;

endpackage

`default_nettype wire

// File: rtl/axi_rd_skid_buf.sv
// Two-entry valid/ready buffer for read beats; space tells the read FSM a new BRAM read may be issued.
`default_nettype none

module axi_rd_skid_buf
    import ddr_axi4_mem_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  rd_beat_t push_beat,
    output logic     out_valid,
    output rd_beat_t out_beat,
    input  logic     out_ready,
    output logic     pop,
    output logic     space
);

    rd_beat_t   entry [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic [2:0] occ_next;

    assign out_valid = (count != 2'd0);
    assign out_beat  = entry[rd_ptr];
    assign pop       = out_valid && out_ready;
    assign occ_next  = 3'(count) + 3'(push) - 3'(pop);
    // A read issued now lands two cycles later, so leave room for it after this cycle's traffic.
    assign space     = (occ_next <= 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry[0] <= '0;
            entry[1] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (push) begin
                entry[wr_ptr] <= push_beat;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= occ_next[1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/ddr_axi4_mem_responder.sv
// AXI4 slave terminating the 64-bit DDR-side shim port with a dual-port on-chip memory.
`default_nettype none

module ddr_axi4_mem_responder
    import ddr_axi4_mem_pkg::*;
#(
    parameter int ID_W   = 16,
    parameter int ADDR_W = 64,
    parameter int DEPTH  = 4096
) (
    input  logic              clk_main_a0,
    input  logic              rst_main_n,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic [ID_W-1:0]   s_awid,
    input  logic [7:0]        s_awlen,
    input  logic [2:0]        s_awsize,
    input  logic              s_wvalid,
    output logic              s_wready,
    input  logic [63:0]       s_wdata,
    input  logic [7:0]        s_wstrb,
    input  logic              s_wlast,
    output logic              s_bvalid,
    input  logic              s_bready,
    output logic [ID_W-1:0]   s_bid,
    output logic [1:0]        s_bresp,
    input  logic              s_arvalid,
    output logic              s_arready,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic [ID_W-1:0]   s_arid,
    input  logic [7:0]        s_arlen,
    input  logic [2:0]        s_arsize,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [63:0]       s_rdata,
    output logic [ID_W-1:0]   s_rid,
    output logic [1:0]        s_rresp,
    output logic              s_rlast,
    output logic [15:0]       err_count
);

    localparam int                IDX_W     = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(DEPTH * BEAT_BYTES);
    localparam logic [ADDR_W-1:0] ADDR_INC  = ADDR_W'(BEAT_BYTES);

    // Assert asynchronously, release two clocks after rst_main_n rises.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    logic [63:0] mem [DEPTH];

    wr_state_e         wr_state;
    logic [ID_W-1:0]   wr_id;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_len;
    logic [7:0]        wr_beat;
    logic              wr_err;
    logic              aw_fire;
    logic              w_fire;
    logic              wr_in_range;
    logic              wr_beat_last;
    logic              wr_beat_err;
    logic              mem_we;
    logic [IDX_W-1:0]  wr_idx;

    assign aw_fire      = s_awvalid && s_awready;
    assign w_fire       = s_wvalid && s_wready;
    assign wr_in_range  = (wr_addr < MEM_BYTES);
    assign wr_beat_last = (wr_beat == wr_len);
    assign wr_beat_err  = !wr_in_range || (s_wlast != wr_beat_last);
    assign mem_we       = w_fire && wr_in_range && !wr_err;
    assign wr_idx       = wr_addr[3 +: IDX_W];

    always_ff @(posedge clk_main_a0 or negedge rst_n) begin
        if (!rst_n) begin
            wr_state  <= W_IDLE;
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            s_bvalid  <= 1'b0;
            s_bid     <= '0;
            s_bresp   <= RESP_OKAY;
            wr_id     <= '0;
            wr_addr   <= '0;
            wr_len    <= 8'd0;
            wr_beat   <= 8'd0;
            wr_err    <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    s_awready <= 1'b1;
                    if (aw_fire) begin
                        wr_id     <= s_awid;
                        wr_addr   <= s_awaddr;
                        wr_len    <= s_awlen;
                        wr_beat   <= 8'd0;
                        wr_err    <= (s_awsize != SIZE_64);
                        s_awready <= 1'b0;
                        s_wready  <= 1'b1;
                        wr_state  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        wr_addr <= wr_addr + ADDR_INC;
                        wr_beat <= wr_beat + 8'd1;
                        wr_err  <= wr_err || wr_beat_err;
                        // The beat count, not wlast, closes the burst.
                        if (wr_beat_last) begin
                            s_wready <= 1'b0;
                            s_bvalid <= 1'b1;
                            s_bid    <= wr_id;
                            s_bresp  <= (wr_err || wr_beat_err) ? RESP_SLVERR : RESP_OKAY;
                            wr_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_bready) begin
                        s_bvalid  <= 1'b0;
                        s_awready <= 1'b1;
                        wr_state  <= W_IDLE;
                    end
                end
                default: begin
                    wr_state <= W_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_main_a0) begin
        if (mem_we) begin
            for (int b = 0; b < BEAT_BYTES; b++) begin
                if (s_wstrb[b]) begin
                    mem[wr_idx][8*b +: 8] <= s_wdata[8*b +: 8];
                end
            end
        end
    end

    rd_state_e         rd_state;
    logic [ID_W-1:0]   rd_id;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_len;
    logic [8:0]        rd_issued;
    logic              rd_err;
    logic              rd_burst_err;
    logic              ar_fire;
    logic              rd_in_range;
    logic              rd_issue;
    logic              rd_en;
    logic [IDX_W-1:0]  rd_idx;
    logic [63:0]       rd_q;
    logic              p_valid;
    logic              p_bad;
    logic              p_last;
    rd_beat_t          push_beat;
    rd_beat_t          out_beat;
    logic              out_valid;
    logic              r_pop;
    logic              skid_space;

    assign ar_fire     = s_arvalid && s_arready;
    assign rd_in_range = (rd_addr < MEM_BYTES);
    assign rd_issue    = (rd_state == R_DATA) && (rd_issued <= {1'b0, rd_len}) && skid_space;
    assign rd_en       = rd_issue && rd_in_range && !rd_err;
    assign rd_idx      = rd_addr[3 +: IDX_W];

    // Write-port updates land after this read samples, giving read-first collisions.
    always_ff @(posedge clk_main_a0) begin
        if (rd_en) begin
            rd_q <= mem[rd_idx];
        end
    end

    always_ff @(posedge clk_main_a0 or negedge rst_n) begin
        if (!rst_n) begin
            p_valid <= 1'b0;
            p_bad   <= 1'b0;
            p_last  <= 1'b0;
        end else begin
            p_valid <= rd_issue;
            if (rd_issue) begin
                p_bad  <= !rd_in_range || rd_err;
                p_last <= (rd_issued[7:0] == rd_len);
            end
        end
    end

    always_comb begin
        push_beat      = '0;
        push_beat.data = p_bad ? 64'd0 : rd_q;
        push_beat.id   = ID_MAX_W'(rd_id);
        push_beat.resp = p_bad ? RESP_SLVERR : RESP_OKAY;
        push_beat.last = p_last;
    end

    axi_rd_skid_buf u_skid (
        .clk       (clk_main_a0),
        .rst_n     (rst_n),
        .push      (p_valid),
        .push_beat (push_beat),
        .out_valid (out_valid),
        .out_beat  (out_beat),
        .out_ready (s_rready),
        .pop       (r_pop),
        .space     (skid_space)
    );

    assign s_rvalid = out_valid;
    assign s_rdata  = out_beat.data;
    assign s_rid    = out_beat.id[ID_W-1:0];
    assign s_rresp  = out_beat.resp;
    assign s_rlast  = out_beat.last;

    always_ff @(posedge clk_main_a0 or negedge rst_n) begin
        if (!rst_n) begin
            rd_state     <= R_IDLE;
            s_arready    <= 1'b0;
            rd_id        <= '0;
            rd_addr      <= '0;
            rd_len       <= 8'd0;
            rd_issued    <= 9'd0;
            rd_err       <= 1'b0;
            rd_burst_err <= 1'b0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    s_arready <= 1'b1;
                    if (ar_fire) begin
                        rd_id        <= s_arid;
                        rd_addr      <= s_araddr;
                        rd_len       <= s_arlen;
                        rd_issued    <= 9'd0;
                        rd_err       <= (s_arsize != SIZE_64);
                        rd_burst_err <= 1'b0;
                        s_arready    <= 1'b0;
                        rd_state     <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rd_issue) begin
                        rd_addr   <= rd_addr + ADDR_INC;
                        rd_issued <= rd_issued + 9'd1;
                    end
                    if (r_pop) begin
                        if (out_beat.last) begin
                            rd_burst_err <= 1'b0;
                            s_arready    <= 1'b1;
                            rd_state     <= R_IDLE;
                        end else if (out_beat.resp == RESP_SLVERR) begin
                            rd_burst_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    rd_state <= R_IDLE;
                end
            endcase
        end
    end

    // One count per erroring B response and per erroring R burst, saturating.
    logic        wr_err_inc;
    logic        rd_err_inc;
    logic [16:0] err_sum;

    assign wr_err_inc = s_bvalid && s_bready && (s_bresp == RESP_SLVERR);
    assign rd_err_inc = r_pop && out_beat.last && (rd_burst_err || (out_beat.resp == RESP_SLVERR));
    assign err_sum    = {1'b0, err_count} + 17'(wr_err_inc) + 17'(rd_err_inc);

    always_ff @(posedge clk_main_a0 or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= 16'd0;
        end else begin
            err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ddr_axi4_mem_responder.sv
// Randomised self-checking bench for ddr_axi4_mem_responder against a word-array memory model.
`default_nettype none

module tb_ddr_axi4_mem_responder;

    localparam int          DEPTH     = 4096;
    localparam int          IDX_W     = 12;
    localparam logic [63:0] MEM_BYTES = 64'(DEPTH * 8);

    logic        clk_main_a0 = 1'b0;
    logic        rst_main_n  = 1'b0;
    logic        s_awvalid = 1'b0, s_awready;
    logic [63:0] s_awaddr = '0;
    logic [15:0] s_awid = '0;
    logic [7:0]  s_awlen = '0;
    logic [2:0]  s_awsize = '0;
    logic        s_wvalid = 1'b0, s_wready;
    logic [63:0] s_wdata = '0;
    logic [7:0]  s_wstrb = '0;
    logic        s_wlast = 1'b0;
    logic        s_bvalid, s_bready = 1'b0;
    logic [15:0] s_bid;
    logic [1:0]  s_bresp;
    logic        s_arvalid = 1'b0, s_arready;
    logic [63:0] s_araddr = '0;
    logic [15:0] s_arid = '0;
    logic [7:0]  s_arlen = '0;
    logic [2:0]  s_arsize = '0;
    logic        s_rvalid, s_rready = 1'b0;
    logic [63:0] s_rdata;
    logic [15:0] s_rid;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic [15:0] err_count;

    int checks = 0;
    int errors = 0;
    int exp_err_count = 0;

    logic [63:0] ref_mem [DEPTH];
    bit          known   [DEPTH];
    logic [63:0] wd [256];
    logic [7:0]  ws [256];

    ddr_axi4_mem_responder dut (
        .clk_main_a0 (clk_main_a0), .rst_main_n (rst_main_n),
        .s_awvalid (s_awvalid), .s_awready (s_awready), .s_awaddr (s_awaddr),
        .s_awid (s_awid), .s_awlen (s_awlen), .s_awsize (s_awsize),
        .s_wvalid (s_wvalid), .s_wready (s_wready), .s_wdata (s_wdata),
        .s_wstrb (s_wstrb), .s_wlast (s_wlast),
        .s_bvalid (s_bvalid), .s_bready (s_bready), .s_bid (s_bid), .s_bresp (s_bresp),
        .s_arvalid (s_arvalid), .s_arready (s_arready), .s_araddr (s_araddr),
        .s_arid (s_arid), .s_arlen (s_arlen), .s_arsize (s_arsize),
        .s_rvalid (s_rvalid), .s_rready (s_rready), .s_rdata (s_rdata),
        .s_rid (s_rid), .s_rresp (s_rresp), .s_rlast (s_rlast),
        .err_count (err_count)
    );

    always #5 clk_main_a0 = ~clk_main_a0;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_err_count(input string tag);
        checks++;
        if (err_count !== 16'(exp_err_count)) begin
            errors++;
            $display("FAIL err_count (%s): got %0d want %0d", tag, err_count, exp_err_count);
        end
    endtask

    // Model first, then drive; starts and ends on a falling edge.
    task automatic do_write(input logic [63:0] addr, input int len, input logic [2:0] size,
                            input logic [15:0] id, input int bad_wlast, input bit gaps);
        bit          err, inr, hs, done;
        logic [63:0] a;
        int          idx, n;
        err = (size != 3'd3);
        for (int i = 0; i <= len; i++) begin
            a   = addr + 64'(8 * i);
            inr = (a < MEM_BYTES);
            if (inr && !err) begin
                idx = int'(a[3 +: IDX_W]);
                for (int b = 0; b < 8; b++)
                    if (ws[i][b]) ref_mem[idx][8*b +: 8] = wd[i][8*b +: 8];
                if (ws[i] == 8'hFF) known[idx] = 1'b1;
            end
            if (!inr) err = 1'b1;
            if (i == bad_wlast) err = 1'b1;
        end
        s_awaddr = addr; s_awlen = 8'(len); s_awsize = size; s_awid = id; s_awvalid = 1'b1;
        n = 0;
        do begin hs = s_awready; @(negedge clk_main_a0); n++; end while (!hs && n < 20);
        s_awvalid = 1'b0;
        checks++;
        if (!hs) begin errors++; $display("FAIL aw_handshake: awready=0 want 1 within 20 cycles"); return; end
        checks++;
        if (s_wready !== 1'b1) begin
            errors++; $display("FAIL aw_to_wready: wready=%b want 1 one cycle after AW", s_wready);
        end
        for (int i = 0; i <= len; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin s_wvalid = 1'b0; @(negedge clk_main_a0); end
            s_wdata = wd[i]; s_wstrb = ws[i]; s_wlast = (i == len) ^ (i == bad_wlast); s_wvalid = 1'b1;
            n = 0;
            do begin hs = s_wready; @(negedge clk_main_a0); n++; end while (!hs && n < 20);
            if (!hs) begin
                checks++; errors++; s_wvalid = 1'b0;
                $display("FAIL w_handshake beat %0d: wready=0 want 1 within 20 cycles", i);
                return;
            end
        end
        s_wvalid = 1'b0; s_wlast = 1'b0;
        n = 0; done = 1'b0;
        while (!done && n < 40) begin
            s_bready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            if (s_bvalid && s_bready) begin
                checks++;
                if (s_bid !== id || s_bresp !== (err ? 2'b10 : 2'b00)) begin
                    errors++;
                    $display("FAIL bresp: bid=%h bresp=%b want bid=%h bresp=%b",
                             s_bid, s_bresp, id, err ? 2'b10 : 2'b00);
                end
                done = 1'b1;
            end
            @(negedge clk_main_a0); n++;
        end
        s_bready = 1'b0;
        checks++;
        if (!done) begin errors++; $display("FAIL b_timeout: bvalid=0 want 1 within 40 cycles"); end
        if (err) exp_err_count++;
        check_err_count("write");
    endtask

    // mode 0: rready always 1 (latency/throughput checked), 1: random, 2: 1,0,0,1 pattern.
    task automatic do_read(input logic [63:0] addr, input int len, input logic [2:0] size,
                           input logic [15:0] id, input int mode);
        bit          hs, held, burst_err, bad;
        int          n, k, got, first_k, last_k, idx;
        logic [63:0] a, exp_d, sv_d;
        logic [15:0] sv_id;
        logic [1:0]  sv_resp;
        logic        sv_last;
        s_araddr = addr; s_arlen = 8'(len); s_arsize = size; s_arid = id; s_arvalid = 1'b1;
        n = 0;
        do begin hs = s_arready; @(negedge clk_main_a0); n++; end while (!hs && n < 20);
        s_arvalid = 1'b0;
        checks++;
        if (!hs) begin errors++; $display("FAIL ar_handshake: arready=0 want 1 within 20 cycles"); return; end
        k = 0; got = 0; held = 1'b0; first_k = -1; last_k = -1; burst_err = 1'b0;
        sv_d = '0; sv_id = '0; sv_resp = '0; sv_last = 1'b0;
        while (got <= len && k < 400) begin
            if (held) begin
                checks++;
                if ({s_rvalid, s_rdata, s_rid, s_rresp, s_rlast} !== {1'b1, sv_d, sv_id, sv_resp, sv_last}) begin
                    errors++;
                    $display("FAIL stall_hold beat %0d: got v=%b d=%h id=%h resp=%b last=%b want v=1 d=%h id=%h resp=%b last=%b",
                             got, s_rvalid, s_rdata, s_rid, s_rresp, s_rlast, sv_d, sv_id, sv_resp, sv_last);
                end
            end
            case (mode)
                0:       s_rready = 1'b1;
                1:       s_rready = 1'($urandom_range(0, 1));
                default: s_rready = ((k % 4) == 0) || ((k % 4) == 3);
            endcase
            if (s_rvalid && first_k < 0) first_k = k;
            held = 1'b0;
            if (s_rvalid && s_rready) begin
                a     = addr + 64'(8 * got);
                bad   = (size != 3'd3) || (a >= MEM_BYTES);
                idx   = int'(a[3 +: IDX_W]);
                exp_d = bad ? 64'd0 : ref_mem[idx];
                if (bad) burst_err = 1'b1;
                checks++;
                if (s_rid !== id || s_rresp !== (bad ? 2'b10 : 2'b00) || s_rlast !== (got == len) ||
                    ((bad || known[idx]) && s_rdata !== exp_d)) begin
                    errors++;
                    $display("FAIL rbeat %0d: got d=%h id=%h resp=%b last=%b want d=%h id=%h resp=%b last=%b",
                             got, s_rdata, s_rid, s_rresp, s_rlast, exp_d, id, bad ? 2'b10 : 2'b00, got == len);
                end
                got++; last_k = k;
            end else if (s_rvalid) begin
                held = 1'b1; sv_d = s_rdata; sv_id = s_rid; sv_resp = s_rresp; sv_last = s_rlast;
            end
            @(negedge clk_main_a0); k++;
        end
        s_rready = 1'b0;
        checks++;
        if (got != len + 1 || s_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL r_beats: got %0d beats rvalid_after=%b want %0d beats rvalid_after=0", got, s_rvalid, len + 1);
        end
        if (mode == 0) begin
            checks++;
            if (first_k != 2 || last_k - first_k != len) begin
                errors++;
                $display("FAIL r_latency: first rvalid %0d span %0d want first 2 span %0d", first_k, last_k - first_k, len);
            end
        end
        if (burst_err) exp_err_count++;
        check_err_count("read");
    endtask

    task automatic wait_ready_after_release(input string tag);
        int n;
        n = 0;
        while (!(s_awready && s_arready) && n < 6) begin @(negedge clk_main_a0); n++; end
        checks++;
        if (!(s_awready && s_arready) || n > 3) begin
            errors++;
            $display("FAIL %s: ready after %0d cycles (aw=%b ar=%b) want both 1 within 3", tag, n, s_awready, s_arready);
        end
    endtask

    task automatic test_reset();
        @(negedge clk_main_a0);
        checks++;
        if ({s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_bid, s_bresp, s_rdata, s_rid, s_rresp, s_rlast, err_count} !== '0) begin
            errors++;
            $display("FAIL reset_values: aw=%b w=%b b=%b ar=%b r=%b bid=%h bresp=%b rdata=%h rid=%h rresp=%b rlast=%b err=%0d want all 0",
                     s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_bid, s_bresp, s_rdata, s_rid, s_rresp, s_rlast, err_count);
        end
        #1 rst_main_n = 1'b1;
        wait_ready_after_release("reset_release");
    endtask

    task automatic test_basic();
        for (int i = 0; i < 4; i++) begin wd[i] = 64'((i + 1) * 8'h11); ws[i] = 8'hFF; end
        do_write(64'h100, 3, 3'd3, 16'h5, -1, 1'b0);
        do_read(64'h100, 3, 3'd3, 16'h6, 0);
    endtask

    task automatic test_strobe();
        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
        do_write(64'h0, 0, 3'd3, 16'h1, -1, 1'b0);
        wd[0] = 64'h0000_0000_0000_00AB; ws[0] = 8'h01;
        do_write(64'h0, 0, 3'd3, 16'h2, -1, 1'b0);
        do_read(64'h0, 0, 3'd3, 16'h3, 0);
    endtask

    task automatic test_out_of_range();
        for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
        do_write(MEM_BYTES - 64'd16, 3, 3'd3, 16'h9, -1, 1'b0);
        do_read(MEM_BYTES - 64'd16, 3, 3'd3, 16'hA, 0);
    endtask

    task automatic test_stall();
        for (int i = 0; i < 16; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
        do_write(64'h800, 15, 3'd3, 16'h10, -1, 1'b0);
        do_read(64'h800, 15, 3'd3, 16'h11, 2);
    endtask

    task automatic test_wlast_and_size();
        for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
        do_write(64'h3000, 3, 3'd3, 16'h20, 1, 1'b0);
        for (int i = 0; i < 2; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
        do_write(64'h3100, 1, 3'd3, 16'h21, -1, 1'b0);
        for (int i = 0; i < 2; i++) begin wd[i] = ~wd[i]; ws[i] = 8'hFF; end
        do_write(64'h3100, 1, 3'd2, 16'h22, -1, 1'b0);
        do_read(64'h3100, 1, 3'd3, 16'h23, 0);
        do_read(64'h3100, 1, 3'd2, 16'h24, 0);
    endtask

    task automatic test_random();
        logic [63:0] addr;
        int          len;
        for (int it = 0; it < 14; it++) begin
            addr = 64'h1000 + 64'($urandom_range(0, 255)) * 64'd8;
            len  = $urandom_range(0, 7);
            for (int i = 0; i <= len; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
            do_write(addr, len, 3'd3, 16'($urandom), -1, 1'b1);
            for (int i = 0; i <= len; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); end
            do_write(addr, len, 3'd3, 16'($urandom), -1, 1'b1);
            do_read(addr, len, 3'd3, 16'($urandom), (it % 3 == 0) ? 0 : 1);
        end
    endtask

    task automatic test_reset_midburst();
        bit hs;
        int n;
        s_araddr = 64'h800; s_arlen = 8'd15; s_arsize = 3'd3; s_arid = 16'h7; s_arvalid = 1'b1;
        n = 0;
        do begin hs = s_arready; @(negedge clk_main_a0); n++; end while (!hs && n < 20);
        s_arvalid = 1'b0; s_rready = 1'b1;
        repeat (5) @(negedge clk_main_a0);
        checks++;
        if (s_rvalid !== 1'b1) begin errors++; $display("FAIL midburst_active: rvalid=%b want 1", s_rvalid); end
        #2 rst_main_n = 1'b0;
        #1;
        checks++;
        if (s_rvalid !== 1'b0 || s_arready !== 1'b0) begin
            errors++; $display("FAIL reset_async: rvalid=%b arready=%b want 0 0", s_rvalid, s_arready);
        end
        s_rready = 1'b0;
        repeat (2) @(negedge clk_main_a0);
        #1 rst_main_n = 1'b1;
        exp_err_count = 0;
        wait_ready_after_release("midburst_release");
        check_err_count("after_reset");
        do_read(64'h800, 15, 3'd3, 16'h8, 0);
        do_read(64'h100, 3, 3'd3, 16'h9, 1);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin ref_mem[i] = '0; known[i] = 1'b0; end
        test_reset();
        test_basic();
        test_strobe();
        test_out_of_range();
        test_stall();
        test_wlast_and_size();
        test_random();
        test_reset_midburst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ddr_axi4_mem_responder.md
Name: ddr_axi4_mem_responder

Overview:
- AXI4 responder that terminates the 64-bit DDR-side master port of the FireSim shim with an on-chip BRAM memory.
- Used for bring-up and simulation in place of DDR C, so that shim memory traffic can run without the shell DDR controller.
- Supports INCR bursts, write strobes, and ID echo, with one outstanding write burst and one outstanding read burst at a time.

Parameters:
- ID_W, 16, width of AWID/ARID/BID/RID.
- ADDR_W, 64, AXI address width.
- DEPTH, 4096, memory depth in 64-bit words; must be a power of two.

Ports:
- clk_main_a0  in  1  clock
- rst_main_n  in  1  reset, asynchronous, active-low
- s_awvalid/s_awready  in/out  1  write address handshake
- s_awaddr  in  ADDR_W  byte address
- s_awid  in  ID_W  write ID
- s_awlen  in  8  beats minus one
- s_awsize  in  3  log2 of bytes per beat
- s_wvalid/s_wready  in/out  1  write data handshake
- s_wdata  in  64  write data
- s_wstrb  in  8  byte enables
- s_wlast  in  1  last-beat marker
- s_bvalid/s_bready  out/in  1  write response handshake
- s_bid  out  ID_W  response ID
- s_bresp  out  2  response code
- s_arvalid/s_arready  in/out  1  read address handshake
- s_araddr  in  ADDR_W  byte address
- s_arid  in  ID_W  read ID
- s_arlen  in  8  beats minus one
- s_arsize  in  3  log2 of bytes per beat
- s_rvalid/s_rready  out/in  1  read data handshake
- s_rdata  out  64  read data
- s_rid  out  ID_W  read ID
- s_rresp  out  2  response code
- s_rlast  out  1  last-beat marker
- err_count  out  16  saturating count of SLVERR responses

Behaviour:
- Reset: rst_main_n asserts asynchronously; deassertion is synchronised internally with a 2-flop synchroniser on clk_main_a0.
  - Reset values: all valids and readys 0; bid/rid/bresp/rresp/rdata/rlast 0; err_count 0; both FSMs return to IDLE.
  - BRAM contents are not cleared.
  - Reset mid-burst abandons the burst with no response.
- Address decode:
  - Word index = addr[3 +: log2(DEPTH)].
  - A beat is in range iff the beat's byte address < DEPTH*8.
  - Beat address increments by 8 per beat; no wrap.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: awready=1. On AW handshake, capture id, addr, len, size; clear beat count and the error flag; go to W_DATA.
  - Error flag is set at AW capture if awsize != 3.
  - W_DATA: wready=1. Each W handshake writes the bytes selected by wstrb, but only if the beat is in range and the error flag is clear.
  - An out-of-range beat sets the error flag.
  - wlast must equal (beat == len); a mismatch sets the error flag.
  - The burst ends on handshake of beat len, independent of wlast; go to W_RESP.
  - W_RESP: bvalid=1, bid = captured id, bresp = 2'b10 if the error flag is set, else 2'b00. Hold until bready, then go to W_IDLE.
  - AW-to-first-wready latency: 1 cycle.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: arready=1. On AR handshake, capture fields and go to R_DATA.
  - Error is set at capture if arsize != 3.
  - R_DATA: issues synchronous BRAM reads (1-cycle latency) into a 2-entry skid buffer.
    - A read is issued while the buffer has space or will drain this cycle.
    - rid and rresp travel with the data.
    - Out-of-range or error beats return rdata=0 and rresp=2'b10.
    - rlast=1 on beat len.
  - Return to R_IDLE after the rlast handshake.
  - First rvalid occurs 2 cycles after the AR handshake.
  - Sustained throughput is 1 beat/cycle with rready held at 1.
  - rvalid/rdata/rid/rresp/rlast remain stable while rvalid=1 and rready=0.
- Simultaneous read and write: the two FSMs are independent; the BRAM is true dual-port.
  - A same-word collision is read-first: the read returns the old data.
- err_count increments by 1 per SLVERR B response and per SLVERR R burst (counted at the rlast handshake); it saturates at 16'hFFFF.

Decomposition:
- Package ddr_axi4_mem_pkg:
  - wr_state_e and rd_state_e enums.
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - BEAT_BYTES = 8.
  - rd_beat_t struct holding data, id, resp, last.
- Sub-module axi_rd_skid_buf: 2-entry valid/ready skid buffer of rd_beat_t, with a space/drain indication to the read FSM.

Test Plan:
- AW addr 0x100, len 3, size 3, ID 0x5, data 0x11..0x44, strb 0xFF, then AR same addr/len, ID 0x6 -> B OKAY, bid 0x5; R returns 0x11, 0x22, 0x33, 0x44, rid 0x6, rlast only on beat 4, first rvalid 2 cycles after AR.
- Write 0xFFFF_FFFF_FFFF_FFFF to 0x0, then 0x0000_0000_0000_00AB with strb 0x01 -> read 0x0 returns 0xFFFF_FFFF_FFFF_FFAB.
- AW addr DEPTH*8-16, len 3 -> only first 2 words written; bresp 2'b10; err_count 1. Read of same range -> beats 3–4 return rdata 0 with rresp 2'b10.
- Read len 15 with rready toggling 1,0,0,1 -> no lost or duplicated beats; data held stable while stalled; 16 beats in order.
- wlast asserted on beat 1 of a len 3 burst -> burst still takes 4 beats; bresp SLVERR. Also awsize 2 -> no memory update and SLVERR.
- rst_main_n pulsed low mid read burst -> rvalid drops to 0 immediately; after release, arready=1 within 3 cycles; memory contents retained.
